// File: rtl/uart_pkg.sv
// Shared types for the UART echo path: byte width, byte type and the
// transmit-launch state encoding.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef logic [DATA_W-1:0] byte_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop level synchroniser for single-bit flags crossing into the clk
// domain. Flops clear to 0 on reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else begin
      stage <= {stage[STAGES-2:0], d};
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/uart_rx_fifo.sv
// Elastic byte queue between the UART receiver and transmitter: pushes on each
// rx_valid rising edge and launches queued bytes with a start/done handshake.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W      = uart_pkg::DATA_W,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic [DATA_W-1:0]        rx_word,
  input  logic                     rx_valid,
  input  logic                     tx_done,
  input  logic                     clr_flags,
  output logic [DATA_W-1:0]        tx_word,
  output logic                     tx_start,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic                     overflow,
  output logic                     tx_timeout
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [TW-1:0] TO_ONE   = TW'(1);
  localparam logic [TW-1:0] TO_LAST  = TW'(ACK_TIMEOUT - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [TW-1:0]     to_cnt;
  state_t            state;
  logic              rx_valid_q;
  logic              tx_done_s;

  logic push;
  logic pop;
  logic push_ok;
  logic drop;
  logic timeout_ev;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_done_sync (
    .clk   (clk),
    .rst_n (res),
    .d     (tx_done),
    .q     (tx_done_s)
  );

  assign fifo_count = count;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_FULL);

  assign push       = rx_valid & ~rx_valid_q;
  assign pop        = (state == IDLE) & ~fifo_empty & tx_done_s;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok    = push & (~fifo_full | pop);
  assign drop       = push & fifo_full & ~pop;
  assign timeout_ev = (state == START) & tx_done_s & (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= rx_word;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      rx_valid_q <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      tx_word    <= '0;
      overflow   <= 1'b0;
      tx_timeout <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        tx_word <= mem[rd_ptr];
      end
      if (push_ok && !pop) begin
        count <= count + CNT_ONE;
      end else if (!push_ok && pop) begin
        count <= count - CNT_ONE;
      end
      // New events take priority over a same-cycle clear.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_flags) begin
        overflow <= 1'b0;
      end
      if (timeout_ev) begin
        tx_timeout <= 1'b1;
      end else if (clr_flags) begin
        tx_timeout <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      to_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            tx_start <= 1'b1;
            to_cnt   <= '0;
            state    <= START;
          end
        end
        START: begin
          if (!tx_done_s) begin
            tx_start <= 1'b0;
            state    <= BUSY;
          end else if (to_cnt == TO_LAST) begin
            tx_start <= 1'b0;
            state    <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_ONE;
          end
        end
        BUSY: begin
          if (tx_done_s) begin
            state <= IDLE;
          end
        end
        default: begin
          tx_start <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_uart_rx_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int SYNC   = 2;
  localparam int ACK    = 1024;

  logic              clk = 1'b0;
  logic              res = 1'b0;
  logic [DATA_W-1:0] rx_word = '0;
  logic              rx_valid = 1'b0;
  logic              clr_flags = 1'b0;
  logic              tb_done = 1'b1;
  logic              xm_done = 1'b1;
  logic              xmit_en = 1'b0;
  logic              tx_done;
  logic [DATA_W-1:0] tx_word;
  logic              tx_start;
  logic [4:0]        fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              overflow;
  logic              tx_timeout;

  assign tx_done = xmit_en ? xm_done : tb_done;

  uart_rx_fifo #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC),
    .ACK_TIMEOUT (ACK)
  ) dut (
    .clk        (clk),
    .res        (res),
    .rx_word    (rx_word),
    .rx_valid   (rx_valid),
    .tx_done    (tx_done),
    .clr_flags  (clr_flags),
    .tx_word    (tx_word),
    .tx_start   (tx_start),
    .fifo_count (fifo_count),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .overflow   (overflow),
    .tx_timeout (tx_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a byte queue plus a transfer phase (0 idle, 1 requesting, 2 sending).
  logic [7:0] q[$];
  logic [7:0] m_word = 8'h00;
  bit         m_start = 1'b0;
  bit         m_ovf = 1'b0;
  bit         m_to = 1'b0;
  int         mode = 0;
  int         age = 0;
  bit         prev_v = 1'b1;
  bit         sh[SYNC];

  initial begin
    for (int i = 0; i < SYNC; i++) sh[i] = 1'b0;
    forever begin
      @(posedge clk or negedge res);
      if (!res) begin
        q.delete();
        m_word = 8'h00; m_start = 0; m_ovf = 0; m_to = 0;
        mode = 0; age = 0; prev_v = 1;
        for (int i = 0; i < SYNC; i++) sh[i] = 1'b0;
      end else begin
        bit ds, was_full, do_pop, do_push, ovf_ev, to_ev;
        ds       = sh[SYNC-1];
        was_full = (q.size() == DEPTH);
        do_pop   = (mode == 0) && (q.size() != 0) && ds;
        do_push  = rx_valid && !prev_v;
        ovf_ev   = 0;
        to_ev    = 0;
        if (mode == 0) begin
          if (do_pop) begin
            m_word = q.pop_front();
            m_start = 1; mode = 1; age = 0;
          end
        end else if (mode == 1) begin
          if (!ds) begin
            m_start = 0; mode = 2;
          end else if (age == ACK - 1) begin
            m_start = 0; to_ev = 1; mode = 0;
          end else begin
            age++;
          end
        end else begin
          if (ds) mode = 0;
        end
        if (do_push) begin
          if (!was_full || do_pop) q.push_back(rx_word);
          else ovf_ev = 1;
        end
        if (ovf_ev) m_ovf = 1; else if (clr_flags) m_ovf = 0;
        if (to_ev) m_to = 1; else if (clr_flags) m_to = 0;
        for (int i = SYNC - 1; i > 0; i--) sh[i] = sh[i-1];
        sh[0] = tx_done;
        prev_v = rx_valid;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      checks++;
      if (tx_word !== m_word || tx_start !== m_start || int'(fifo_count) != q.size() ||
          fifo_empty !== (q.size() == 0) || fifo_full !== (q.size() == DEPTH) ||
          overflow !== m_ovf || tx_timeout !== m_to) begin
        errors++;
        $display("FAIL model_cmp t=%0t word=%0h/%0h start=%0b/%0b count=%0d/%0d empty=%0b full=%0b ovf=%0b/%0b to=%0b/%0b (actual/required)",
                 $time, tx_word, m_word, tx_start, m_start, fifo_count, q.size(),
                 fifo_empty, fifo_full, overflow, m_ovf, tx_timeout, m_to);
      end
    end
  end

  // Transmitter stand-in: accepts on tx_start, stays busy a few cycles.
  logic [7:0] sent[$];
  int xm_hold = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (xmit_en) begin
        if (xm_done && tx_start) begin
          sent.push_back(tx_word);
          xm_done = 1'b0;
          xm_hold = 3;
        end else if (!xm_done) begin
          if (xm_hold == 0) xm_done = 1'b1;
          else xm_hold--;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_word  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    tick(1);
  endtask

  task automatic wait_drain(input int n, input int budget);
    int k;
    k = 0;
    while ((sent.size() < n || !fifo_empty || tx_start) && k < budget) begin
      tick(1);
      k++;
    end
    check("drain_in_budget", int'(k < budget), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_drain[$];

    // Reset state
    tick(3);
    check("rst_empty", int'(fifo_empty), 1);
    check("rst_full", int'(fifo_full), 0);
    check("rst_count", int'(fifo_count), 0);
    check("rst_start", int'(tx_start), 0);
    check("rst_word", int'(tx_word), 0);
    res = 1'b1;
    tick(4);

    // Single byte
    rx_word = 8'h55; rx_valid = 1'b1;
    tick(1);
    check("single_count_push", int'(fifo_count), 1);
    check("single_start_low", int'(tx_start), 0);
    rx_valid = 1'b0;
    tick(1);
    check("single_word", int'(tx_word), 'h55);
    check("single_start", int'(tx_start), 1);
    check("single_count_pop", int'(fifo_count), 0);
    tb_done = 1'b0;
    tick(3);
    check("single_start_drop", int'(tx_start), 0);
    tb_done = 1'b1;
    tick(4);
    tb_done = 1'b0;
    tick(3);

    // Fill and overflow
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    check("fill_count", int'(fifo_count), 16);
    check("fill_full", int'(fifo_full), 1);
    check("fill_no_ovf", int'(overflow), 0);
    push_byte(8'h10);
    check("ovf_set", int'(overflow), 1);
    check("ovf_count", int'(fifo_count), 16);
    clr_flags = 1'b1;
    tick(1);
    clr_flags = 1'b0;
    check("ovf_clear", int'(overflow), 0);

    // Full plus pop in the same cycle
    tb_done = 1'b1;
    tick(2);
    rx_word = 8'hA0; rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    check("fullpop_count", int'(fifo_count), 16);
    check("fullpop_ovf", int'(overflow), 0);
    check("fullpop_start", int'(tx_start), 1);
    check("fullpop_word", int'(tx_word), 'h00);
    tb_done = 1'b0;
    tick(4);

    // Drain with transmitter, then order and wrap over 24 bytes
    xmit_en = 1'b1;
    for (int i = 1; i < 16; i++) exp_drain.push_back(8'(i));
    exp_drain.push_back(8'hA0);
    wait_drain(16, 400);
    check("drain_size", sent.size(), 16);
    for (int i = 0; i < 16 && i < sent.size(); i++) check($sformatf("drain_byte%0d", i), int'(sent[i]), int'(exp_drain[i]));
    tick(12);
    sent.delete();
    for (int i = 0; i < 24; i++) begin
      push_byte(8'(i));
      tick(2);
    end
    wait_drain(24, 600);
    check("order_size", sent.size(), 24);
    for (int i = 0; i < 24 && i < sent.size(); i++) check($sformatf("order_byte%0d", i), int'(sent[i]), i);
    check("order_empty", int'(fifo_empty), 1);
    tick(12);

    // Simultaneous push and pop at count 3
    xmit_en = 1'b0;
    tb_done = 1'b0;
    tick(3);
    push_byte(8'h30);
    push_byte(8'h31);
    push_byte(8'h32);
    check("simul_pre_count", int'(fifo_count), 3);
    tb_done = 1'b1;
    tick(2);
    rx_word = 8'h33; rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    check("simul_count", int'(fifo_count), 3);
    check("simul_word", int'(tx_word), 'h30);
    check("simul_start", int'(tx_start), 1);

    // Timeout with tx_done stuck high
    tick(1023);
    check("to_start_held", int'(tx_start), 1);
    check("to_not_yet", int'(tx_timeout), 0);
    tick(1);
    check("to_start_drop", int'(tx_start), 0);
    check("to_flag", int'(tx_timeout), 1);
    check("to_count", int'(fifo_count), 3);
    tick(1);
    check("to_next_word", int'(tx_word), 'h31);
    check("to_next_count", int'(fifo_count), 2);
    clr_flags = 1'b1;
    tick(1);
    clr_flags = 1'b0;
    check("to_clear", int'(tx_timeout), 0);

    // Asynchronous reset while sending
    tb_done = 1'b0;
    tick(4);
    check("busy_start_low", int'(tx_start), 0);
    #2;
    res = 1'b0;
    rx_valid = 1'b1;
    #1;
    check("arst_count", int'(fifo_count), 0);
    check("arst_empty", int'(fifo_empty), 1);
    check("arst_full", int'(fifo_full), 0);
    check("arst_word", int'(tx_word), 0);
    check("arst_start", int'(tx_start), 0);
    check("arst_ovf", int'(overflow), 0);
    check("arst_to", int'(tx_timeout), 0);
    tick(3);
    res = 1'b1;
    tick(3);
    check("held_valid_not_pushed", int'(fifo_count), 0);
    rx_valid = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
